// File: rtl/dff_pipeline_if.sv
// dff_pipeline_if: valid/ready input and output streams plus occupancy of the pipeline
interface dff_pipeline_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] D;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] Q;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (output in_valid, D, out_ready, input in_ready, out_valid, Q, count);
  modport slave (input in_valid, D, out_ready, output in_ready, out_valid, Q, count);
endinterface

// File: rtl/dff_pipeline.sv
// dff_pipeline: DEPTH-stage handshaked register chain with bubble collapse and sync flush
module dff_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic reset,
  input logic clear,
  dff_pipeline_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH:0] ready;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [CW-1:0] count;
  logic in_xfer;
  logic out_xfer;
  // an empty stage is always ready, so bubbles collapse under backpressure
  always_comb begin
    ready = '0;
    ready[DEPTH] = bus.out_ready;
    for (int i = DEPTH-1; i >= 0; i--) ready[i] = !valid[i] || ready[i+1];
  end
  always_comb begin
    up_valid[0] = bus.in_valid;
    up_data[0] = bus.D;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid[i] = valid[i-1];
      up_data[i] = data[i-1];
    end
  end
  assign in_xfer = bus.in_valid && bus.in_ready;
  assign out_xfer = valid[DEPTH-1] && bus.out_ready;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
      count <= '0;
    end else if (clear) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (ready[i]) begin
          valid[i] <= up_valid[i];
          if (up_valid[i]) data[i] <= up_data[i];
        end
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  assign bus.in_ready = ready[0] && !clear;
  assign bus.out_valid = valid[DEPTH-1];
  assign bus.Q = data[DEPTH-1];
  assign bus.count = count;
endmodule

// File: tb/tb_dff_pipeline.sv
// tb_dff_pipeline: vector table, directed corner sequences and random traffic against a per-word position model
module tb_dff_pipeline;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RV = 8'h00;
  typedef struct {
    logic iv;
    logic [7:0] d;
    logic ordy;
    logic exp_rdy;
    logic exp_ov;
    logic [7:0] exp_q;
    int exp_cnt;
  } vec_t;
  logic clk = 0;
  logic reset = 0;
  logic clear = 0;
  int checks = 0;
  int errors = 0;
  int qd[$];
  int qp[$];
  logic last_in_x, last_out_x, last_rdy;
  logic [7:0] last_q;
  vec_t tbl[8];
  dff_pipeline_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();
  dff_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction
  // each queued word knows its stage; it advances one stage per edge unless the word ahead blocks it
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    logic exp_rdy, exp_ov;
    int lim;
    bus.in_valid = iv;
    bus.D = d;
    bus.out_ready = ordy;
    clear = clr;
    #1;
    exp_rdy = (qd.size() < DEPTH || ordy) && !clr;
    exp_ov = qd.size() > 0 && qp[0] == DEPTH-1;
    check("in_ready", bus.in_ready, exp_rdy);
    last_rdy = bus.in_ready;
    last_in_x = iv && exp_rdy;
    last_out_x = exp_ov && ordy && !clr;
    last_q = bus.Q;
    @(posedge clk);
    if (clr) begin
      qd.delete();
      qp.delete();
    end else begin
      if (exp_ov && ordy) begin
        void'(qd.pop_front());
        void'(qp.pop_front());
      end
      for (int k = 0; k < qp.size(); k++) begin
        if (k == 0) lim = DEPTH-1;
        else lim = qp[k-1] - 1;
        qp[k] = (qp[k] + 1 < lim) ? qp[k] + 1 : lim;
      end
      if (iv && exp_rdy) begin
        qd.push_back(int'(d));
        qp.push_back(0);
      end
    end
    #1;
    exp_ov = qd.size() > 0 && qp[0] == DEPTH-1;
    check("out_valid", bus.out_valid, exp_ov);
    check("count", bus.count, qd.size());
    if (exp_ov) check("Q", bus.Q, qd[0]);
    @(negedge clk);
  endtask
  initial begin
    int pend;
    int got[$];
    for (int k = 1; k <= 8; k++)
      tbl[k-1] = '{iv: 1'b1, d: 8'(k), ordy: 1'b1, exp_rdy: 1'b1, exp_ov: k >= 4,
                   exp_q: (k >= 4) ? 8'(k-3) : RV, exp_cnt: (k < 4) ? k : 4};
    bus.in_valid = 0;
    bus.D = 0;
    bus.out_ready = 0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_Q", bus.Q, RV);
    check("rst_count", bus.count, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset = 1;
    // streaming from empty
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].iv, tbl[k].d, tbl[k].ordy, 0);
      check("tbl_in_ready", last_rdy, tbl[k].exp_rdy);
      check("tbl_out_valid", bus.out_valid, tbl[k].exp_ov);
      check("tbl_Q", bus.Q, tbl[k].exp_q);
      check("tbl_count", bus.count, tbl[k].exp_cnt);
    end
    for (int c = 0; c < 6; c++) step(0, 0, 1, 0);
    // backpressure: four words fill the pipe, the fifth waits
    pend = 10;
    for (int c = 0; c < 5; c++) begin
      step(1, 8'(pend), 0, 0);
      if (last_in_x) pend++;
    end
    check("bp_in_ready", last_rdy, 0);
    check("bp_accepted", pend, 14);
    check("bp_count", bus.count, 4);
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      step(pend <= 14, 8'(pend), 1, 0);
      if (last_in_x) pend++;
      if (last_out_x) got.push_back(int'(last_q));
    end
    check("bp_out_n", got.size(), 5);
    for (int i = 0; i < got.size(); i++) check("bp_order", got[i], 10 + i);
    for (int c = 0; c < 6; c++) step(0, 0, 1, 0);
    // bubble collapse under a stalled consumer
    step(1, 8'hA5, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 8'h3C, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("bub_stage3", dut.data[3], 8'hA5);
    check("bub_stage2", dut.data[2], 8'h3C);
    check("bub_count", bus.count, 2);
    check("bub_in_ready", bus.in_ready, 1);
    // clear a full pipe while a word is offered
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    check("clr_full", bus.count, 4);
    step(1, 8'h77, 1, 1);
    check("clr_in_ready", last_rdy, 0);
    check("clr_out_valid", bus.out_valid, 0);
    check("clr_count", bus.count, 0);
    check("clr_Q", bus.Q, RV);
    for (int c = 0; c < 6; c++) step(0, 0, 1, 0);
    // full pipe streaming in and out together
    for (int c = 0; c < 4; c++) step(1, 8'(20 + c), 0, 0);
    got.delete();
    for (int c = 0; c < 10; c++) begin
      step(1, 8'(24 + c), 1, 0);
      check("full_in_ready", last_rdy, 1);
      check("full_count", bus.count, 4);
      if (last_out_x) got.push_back(int'(last_q));
    end
    check("full_out_n", got.size(), 10);
    for (int i = 0; i < got.size(); i++) check("full_order", got[i], 20 + i);
    // asynchronous reset between edges with the pipe full
    #2;
    reset = 0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_Q", bus.Q, RV);
    check("arst_count", bus.count, 0);
    qd.delete();
    qp.delete();
    @(negedge clk);
    reset = 1;
    bus.in_valid = 0;
    #1;
    check("arst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    for (int c = 0; c < 400; c++)
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dff_pipeline.md
# dff_pipeline

Parametrised pipeline register chain with valid/ready flow control, built as the next generation of the team's single-bit D flip-flop. It moves WIDTH-bit words through DEPTH register stages, stalls under backpressure without losing or duplicating data, and collapses bubbles so an empty stage always accepts. It is used wherever a DFF or a fixed delay line previously sat on a datapath that now needs a handshake, such as retiming long routes or decoupling producer/consumer blocks.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- RESET_VAL, 0, value loaded into every data stage on reset or clear
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush, active-high
- in_valid  input  1  D holds a valid word
- in_ready  output  1  pipeline accepts D this cycle
- D  input  WIDTH  input data word
- out_valid  output  1  Q holds a valid word
- out_ready  input  1  consumer accepts Q this cycle
- Q  output  WIDTH  output data word (last stage)
- count  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- Stage i (0..DEPTH-1) holds data[i] and valid[i]. Stage 0 is fed from D/in_valid. Stage DEPTH-1 drives Q/out_valid.
- ready[DEPTH] = out_ready. ready[i] = !valid[i] || ready[i+1]. in_ready = ready[0] && !clear.
- On each rising edge with clear=0:
  - if ready[i]: valid[i] <= upstream valid, where upstream is in_valid for i=0 and valid[i-1] otherwise;
  - if ready[i] and upstream valid: data[i] <= upstream data;
  - if !ready[i]: stage holds both data and valid.
- A transfer at input is in_valid && in_ready. A transfer at output is out_valid && out_ready.
- Bubble collapse: an invalid stage accepts from upstream even when downstream stalls.
- Data in invalid stages is don't-care internally. Q reflects data[DEPTH-1] at all times.
- count is a registered occupancy counter.
  - Next value = count + input transfer − output transfer.
  - It always equals the popcount of valid[] and never exceeds DEPTH.
- clear=1 at an edge:
  - all valid <= 0, all data <= RESET_VAL, count <= 0;
  - clear has priority over any simultaneous transfer;
  - no input is accepted, because in_ready is low. A word presented at the output that same cycle counts as consumed only if out_ready was high; it is discarded regardless.
- reset low: immediately, without waiting for a clock edge, all valid = 0, all data = RESET_VAL, count = 0. Outputs are therefore out_valid=0 and Q=RESET_VAL. in_ready reads 1 as soon as clear is low.
- Reset asserted mid-stream discards all in-flight words. Deassertion is synchronised externally to clk.

## Timing
- Latency: a word accepted at edge n appears on Q with out_valid=1 after edge n+DEPTH-1, i.e. DEPTH edges after D was sampled, when unstalled.
- Throughput: one word per cycle sustained with out_ready=1.
- Full pipe (count=DEPTH) with out_ready=1 and in_valid=1: in_ready=1, one word in and one out, count unchanged.
- Full pipe with out_ready=0: in_ready=0, and all stages hold.
- Q, out_valid and count are registered outputs.
- in_ready is combinational from out_ready and valid[], through a DEPTH-long AND/OR chain. This path is documented; no register slice is inserted.
- DEPTH=1 degenerates to a single handshaked register: in_ready = !out_valid || out_ready.

## Test plan
- Reset: with the pipe full of data, drive reset low between clock edges. Required: out_valid=0, Q=RESET_VAL, count=0 before the next edge. Release reset, then check in_ready=1.
- Streaming (WIDTH=8, DEPTH=4), out_ready=1, in_valid=1, D=1,2,3,… on successive edges. Required:
  - first out_valid=1 with Q=1 after the 4th edge;
  - then Q=2,3,4… on consecutive cycles;
  - in_ready stays 1 and count settles at 4.
- Backpressure: out_ready=0, offer D=10..14. Required:
  - 10..13 accepted, in_ready=0 while 14 is offered, count=4;
  - then raise out_ready: Q=10,11,12,13,14 in order, with no gaps beyond the pipe latency, no loss and no duplication.
- Bubble collapse: out_ready=0, push 0xA5, idle 2 cycles, then push 0x3C. Required:
  - 0xA5 reaches stage 3 and 0x3C stage 2;
  - count=2 and in_ready=1 throughout.
- Clear: with count=4, assert clear for one edge while in_valid=1 and D=0x77. Required:
  - in_ready=0 during clear;
  - after the edge out_valid=0, count=0, Q=RESET_VAL;
  - 0x77 never appears on Q.
- Simultaneous in/out on full pipe: count=4, out_ready=1, in_valid=1 for 10 cycles. Required: in_ready=1 every cycle, count stays 4, and the output order matches the input order.
